// File: rtl/cpu6502_buswait.sv
// Bus wait-state controller for a 6502 core: on-chip RAM runs at zero wait states,
// one 4 KB page goes to a 4-phase slow-memory handshake, and RDY stalls the CPU meanwhile.
module cpu6502_buswait #(
  parameter logic [3:0] SLOW_PAGE = 4'hD,
  parameter logic [7:0] TIMEOUT   = 8'd200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  input  logic [7:0]  fast_rdata,
  output logic        RDY,
  output logic [7:0]  DI,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        timeout_err
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic          slow_hit_c;
  logic          start_c, ack_c, tmo_c, cnt_inc_c;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] slow_data;
  logic          sel_slow;

  assign slow_hit_c = (AB[AW-1:AW-4] == SLOW_PAGE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, RDY and datapath strobes
  always_comb begin
    state_nxt = state;
    RDY       = 1'b0;
    start_c   = 1'b0;
    ack_c     = 1'b0;
    tmo_c     = 1'b0;
    cnt_inc_c = 1'b0;
    case (state)
      IDLE: begin
        RDY = !slow_hit_c;
        // A still-high ack from the previous handshake blocks a new request
        if (slow_hit_c && !mem_ack) begin
          start_c   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        RDY = !slow_hit_c;
        if (mem_ack) begin
          ack_c     = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == CW'(TIMEOUT - 8'd1)) begin
          tmo_c     = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      DONE: begin
        RDY       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request attributes, wait counter, captured read data and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wait_cnt    <= '0;
      slow_data   <= '0;
      sel_slow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (RDY) sel_slow <= (state == DONE);
      if (start_c) begin
        mem_addr  <= AB;
        mem_we    <= WE;
        mem_wdata <= DO;
        mem_req   <= 1'b1;
        wait_cnt  <= '0;
      end else if (ack_c) begin
        mem_req <= 1'b0;
        if (!mem_we) slow_data <= mem_rdata;
      end else if (tmo_c) begin
        mem_req     <= 1'b0;
        timeout_err <= 1'b1;
        if (!mem_we) slow_data <= 8'hFF;
      end else if (cnt_inc_c) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign DI = sel_slow ? slow_data : fast_rdata;

endmodule

// File: tb/tb_cpu6502_buswait.sv
// Self-checking bench for cpu6502_buswait: expected DI values are queued when an
// access is issued and popped when the data phase arrives.
module tb_cpu6502_buswait;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] AB = 16'h0000;
  logic        WE = 1'b0;
  logic [7:0]  DO = 8'h00;
  logic [7:0]  fast_rdata = 8'h00;
  logic        RDY;
  logic [7:0]  DI;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_slow = 8'h00;

  cpu6502_buswait #(.SLOW_PAGE(4'hD), .TIMEOUT(8'd200)) dut (
    .clk(clk), .reset_n(reset_n), .AB(AB), .WE(WE), .DO(DO), .fast_rdata(fast_rdata),
    .RDY(RDY), .DI(DI), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] sb_pop();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of a fast access after a slow one so DI shows the slow result
  task automatic next_fast(input logic [7:0] fd);
    tick();
    AB = 16'h0200; WE = 1'b0; DO = 8'h00; mem_ack = 1'b0; fast_rdata = fd;
    #1;
  endtask

  // Slow-memory responder plus CPU side for one slow access; returns observations
  task automatic run_slow(input logic [15:0] addr, input logic we, input logic [7:0] wd,
                          input logic [7:0] rd, input int ack_at, input int pre_ack,
                          input bit hold_in_done, output int low, output int nreq,
                          output bit attr_ok, output bit early, output bit done,
                          output logic [7:0] di_first);
    low = 0; nreq = 0; attr_ok = 1'b1; early = 1'b0; done = 1'b0; di_first = 'x;
    AB = addr; WE = we; DO = wd; fast_rdata = 8'h00;
    for (int k = 0; k < TMO + 20; k++) begin
      if (mem_req === 1'b1) begin
        if (k <= pre_ack) early = 1'b1;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wd)) attr_ok = 1'b0;
        mem_ack   = (ack_at >= 0 && nreq >= ack_at);
        mem_rdata = mem_ack ? rd : 8'h00;
        nreq++;
      end else if (nreq > 0) begin
        mem_ack = hold_in_done;
      end else begin
        mem_ack = (k < pre_ack);
      end
      #1;
      if (k == 0) di_first = DI;
      if (RDY === 1'b1) begin
        if (nreq > 0) begin
          done = 1'b1;
          break;
        end
      end else begin
        low++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    AB = 16'h0000; fast_rdata = 8'hA5;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 16'h0000 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_attrs: got addr %h we %b wdata %h want 0/0/0", mem_addr, mem_we, mem_wdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", RDY); end
    checks++; if (DI !== 8'hA5) begin errors++; $display("FAIL reset_di: got %h want a5", DI); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fast_read();
    logic [15:0] addrs [4];
    logic [7:0]  data  [4];
    logic [7:0]  e;
    addrs[0] = 16'h1234; addrs[1] = 16'hCFFF; addrs[2] = 16'hE000; addrs[3] = 16'h0FFF;
    data[0] = 8'h5A;
    for (int i = 1; i < 4; i++) data[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i <= 4; i++) begin
      AB = (i < 4) ? addrs[i] : 16'h0000;
      WE = 1'b0;
      fast_rdata = (i > 0) ? data[i-1] : 8'h00;
      if (i < 4) exp_q.push_back(data[i]);
      #1;
      checks++; if (RDY !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL fast_rdy_req[%0d]: got rdy %b req %b want 1/0", i, RDY, mem_req); end
      if (i > 0) begin
        e = sb_pop();
        checks++; if (DI !== e) begin errors++; $display("FAIL fast_di[%0d]: got %h want %h", i, DI, e); end
      end
      tick();
    end
  endtask

  task automatic test_min_latency();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    exp_q.push_back(8'h3C);
    run_slow(16'hD000, 1'b0, 8'h00, 8'h3C, 0, 0, 1'b0, low, nreq, ok, early, done, dif);
    exp_slow = 8'h3C;
    checks++; if (!done || low != 2 || nreq != 1) begin
      errors++; $display("FAIL min_latency: got done %0b low %0d req %0d want 1/2/1", done, low, nreq); end
    next_fast(8'h11);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL min_latency_di: got %h want %h", DI, e); end
  endtask

  task automatic test_slow_read();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    exp_q.push_back(8'hC3);
    run_slow(16'hD010, 1'b0, 8'h00, 8'hC3, 3, 0, 1'b0, low, nreq, ok, early, done, dif);
    exp_slow = 8'hC3;
    checks++; if (!done || low != 5 || nreq != 4) begin
      errors++; $display("FAIL slow_read_timing: got done %0b low %0d req %0d want 1/5/4", done, low, nreq); end
    checks++; if (!ok) begin errors++; $display("FAIL slow_read_attrs: attributes changed, want stable D010 read"); end
    next_fast(8'h22);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL slow_read_di: got %h want %h", DI, e); end
  endtask

  task automatic test_slow_write();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    exp_q.push_back(exp_slow);
    run_slow(16'hD020, 1'b1, 8'h77, 8'h99, 2, 0, 1'b0, low, nreq, ok, early, done, dif);
    checks++; if (!ok) begin errors++; $display("FAIL slow_write_attrs: attributes not D020/we/77 throughout"); end
    checks++; if (!done || low != 4 || nreq != 3) begin
      errors++; $display("FAIL slow_write_timing: got done %0b low %0d req %0d want 1/4/3", done, low, nreq); end
    next_fast(8'h33);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL slow_write_keeps_data: got %h want %h", DI, e); end
  endtask

  task automatic test_ack_timeout_race();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    exp_q.push_back(8'h4B);
    run_slow(16'hD030, 1'b0, 8'h00, 8'h4B, TMO - 1, 0, 1'b0, low, nreq, ok, early, done, dif);
    exp_slow = 8'h4B;
    checks++; if (!done || nreq != TMO) begin
      errors++; $display("FAIL race_timing: got done %0b req %0d want 1/%0d", done, nreq, TMO); end
    next_fast(8'h44);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL race_di: got %h want %h", DI, e); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_timeout_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    exp_q.push_back(8'hFF);
    run_slow(16'hDFFF, 1'b0, 8'h00, 8'h00, -1, 0, 1'b0, low, nreq, ok, early, done, dif);
    exp_slow = 8'hFF;
    checks++; if (!done || low != TMO + 1 || nreq != TMO) begin
      errors++; $display("FAIL timeout_timing: got done %0b low %0d req %0d want 1/%0d/%0d", done, low, nreq, TMO + 1, TMO); end
    next_fast(8'h55);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL timeout_di: got %h want %h", DI, e); end
    for (int i = 0; i < 3; i++) next_fast(8'h66);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_back_to_back();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    exp_q.push_back(8'h5E);
    run_slow(16'hD100, 1'b0, 8'h00, 8'h5E, 1, 0, 1'b1, low, nreq, ok, early, done, dif);
    exp_slow = 8'h5E;
    checks++; if (!done || low != 3 || nreq != 2) begin
      errors++; $display("FAIL rmw_read_timing: got done %0b low %0d req %0d want 1/3/2", done, low, nreq); end
    tick();
    exp_q.push_back(exp_slow);
    run_slow(16'hD100, 1'b1, 8'hA1, 8'h00, 0, 2, 1'b0, low, nreq, ok, early, done, dif);
    e = sb_pop();
    checks++; if (dif !== e) begin errors++; $display("FAIL rmw_read_di: got %h want %h", dif, e); end
    checks++; if (early) begin errors++; $display("FAIL rmw_wait_ack_low: got mem_req 1 while ack high want 0"); end
    checks++; if (!done || low != 4 || nreq != 1 || !ok) begin
      errors++; $display("FAIL rmw_write_timing: got done %0b low %0d req %0d attrs %0b want 1/4/1/1", done, low, nreq, ok); end
    next_fast(8'h77);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL rmw_write_di: got %h want %h", DI, e); end
  endtask

  task automatic test_reset_mid_req();
    int low, nreq; bit ok, early, done; logic [7:0] dif, e;
    tick();
    AB = 16'hD200; WE = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midreq_pre: got mem_req %b want 1", mem_req); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL midreq_reset: got req %b addr %h want 0/0000", mem_req, mem_addr); end
    checks++; if (timeout_err !== 1'b0 || RDY !== 1'b0) begin
      errors++; $display("FAIL midreq_reset_flags: got terr %b rdy %b want 0/0", timeout_err, RDY); end
    tick();
    reset_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    #1;
    checks++; if (mem_req !== 1'b0 || RDY !== 1'b0) begin
      errors++; $display("FAIL late_ack_idle: got req %b rdy %b want 0/0", mem_req, RDY); end
    tick();
    exp_q.push_back(8'h6D);
    run_slow(16'hD200, 1'b0, 8'h00, 8'h6D, 0, 0, 1'b0, low, nreq, ok, early, done, dif);
    checks++; if (!done || low != 2 || nreq != 1) begin
      errors++; $display("FAIL after_reset_access: got done %0b low %0d req %0d want 1/2/1", done, low, nreq); end
    next_fast(8'h88);
    e = sb_pop();
    checks++; if (DI !== e) begin errors++; $display("FAIL after_reset_di: got %h want %h", DI, e); end
  endtask

  initial begin
    test_reset();
    test_fast_read();
    test_min_latency();
    test_slow_read();
    test_slow_write();
    test_ack_timeout_race();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
